pipe_wb_regfile: RTL
====================

// Module: pipe_wb_regfile
// PURPOSE
//  Write-back end of the EXE result path: takes the (dest reg, result) stream retired from WB and
//  sources the ID-stage operands that later become ea/eb.
//  32x32 register file, 2 async read ports, 1 sync write port, r0 hard-wired zero.
//  Per-register pending-write scoreboard: ID-side stall logic sees operands with in-flight writes.
// PARAMETERS
//  NREG   32  number of architectural registers (power of 2)
//  DW     32  data width
//  AW      5  register index width, log2(NREG)
//  CW      2  pending-write counter width per register (max 3 writes in flight: EXE/MEM/WB)
// PORTS
//  clock     in   1   single clock; all state updates on rising edge
//  resetn    in   1   synchronous reset, active low
//  rna       in   AW  read port A index
//  rnb       in   AW  read port B index
//  qa        out  DW  read port A data (combinational)
//  qb        out  DW  read port B data (combinational)
//  busya     out  1   rna has pending count != 0 (combinational)
//  busyb     out  1   rnb has pending count != 0 (combinational)
//  iss       in   1   ID issues an instruction that will write register issrn
//  issrn     in   AW  destination of issuing instruction (jal issues 31)
//  wwreg     in   1   WB write enable
//  wrn       in   AW  WB destination index
//  wdi       in   DW  WB write data
//  sb_err    out  1   sticky protocol-error flag
// BEHAVIOUR
//  Reset: all regs 0, all pending counters 0, sb_err 0. qa/qb/busya/busyb follow from that state.
//  Write: on clock edge with wwreg=1 and wrn!=0, reg[wrn] <= wdi. Writes to r0 are dropped.
//  Read: qa = reg[rna], qb = reg[rnb]; index 0 always reads 0. Zero added latency.
//  Scoreboard, per register r, evaluated each clock edge:
//   inc = iss && issrn==r && r!=0 ; dec = wwreg && wrn==r && r!=0
//   inc&!dec -> cnt+1 ; dec&!inc -> cnt-1 ; both or neither -> cnt unchanged.
//  Boundaries:
//   inc at cnt==max (all ones): cnt holds max, sb_err <= 1.
//   dec at cnt==0 (write without issue): cnt holds 0, sb_err <= 1; data write still performed.
//   sb_err clears only on reset.
//   busy* reflects registered cnt; same-cycle dec does not clear busy (bypass below covers data).
//   iss/wwreg with index 0: no counter change, no error.
//  Reset asserted mid-operation: regs, counters and sb_err cleared that edge; iss/wwreg that cycle ignored.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: read port returns wdi when wwreg && wrn==rn && rn!=0 (write-through,
//   same cycle); busy* also suppressed when that write is cnt's last (cnt==1) and not re-issued that cycle.
//  Not defined: reads return pre-edge register contents; busy* purely registered.
//   WB-to-ID hazard then needs one extra stall cycle.
// STRUCTURE
//  Shared package (pipe_pkg): AW/DW/NREG constants, REG_ZERO=0, REG_RA=31.
//  One sub-module: pipe_sb_cnt (single CW-bit saturating up/down counter with err output),
//   instantiated NREG-1 times via generate; sb_err = registered OR of instance errors.
//  Storage and read muxes inline in top.
// TESTING
//  1 reset: resetn=0 two cycles, then read all 32 indices -> qa=qb=0, busya=busyb=0, sb_err=0.
//  2 write/read: wwreg=1 wrn=5 wdi=32'hDEADBEEF; next cycle rna=5 -> qa=DEADBEEF;
//    wrn=0 wdi=1 -> rna=0 gives 0.
//  3 scoreboard: iss issrn=8 three cycles -> busya(rna=8)=1, cnt=3; three wwreg wrn=8 -> busya=0
//    after third, sb_err=0.
//  4 overflow/underflow: 4th iss to r8 at cnt=3 -> sb_err=1, cnt stays 3;
//    after reset, wwreg wrn=9 with cnt=0 -> sb_err=1, reg[9] written.
//  5 simultaneous: iss issrn=31 and wwreg wrn=31 same cycle with cnt=1 -> cnt stays 1, busy stays 1.
//  6 bypass: wwreg wrn=3 wdi=7 with rnb=3 same cycle -> qb=7 if REGFILE_BYPASS_EN,
//    else old value; run both builds.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and scoreboard-counter helpers for the write-back register file.
package pipe_pkg;

   localparam int NREG = 32;
   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int CW   = 2;

   localparam logic [AW-1:0] REG_ZERO = AW'(0);
   localparam logic [AW-1:0] REG_RA   = AW'(31);

   typedef enum logic [1:0] {
      SB_HOLD = 2'd0,
      SB_INC  = 2'd1,
      SB_DEC  = 2'd2
   } sb_op_e;

   // An issue and a retire of the same register in one cycle cancel out.
   function automatic sb_op_e sb_op(input logic inc, input logic dec);
      if (inc && !dec)      return SB_INC;
      else if (dec && !inc) return SB_DEC;
      else                  return SB_HOLD;
   endfunction

endpackage

// File: rtl/pipe_sb_cnt.sv
// Saturating up/down pending-write counter for one register; o_err flags an
// increment at full scale or a decrement at zero in the current cycle.
module pipe_sb_cnt
   import pipe_pkg::*;
#(
   parameter int W = CW
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         i_inc,
   input  logic         i_dec,
   output logic [W-1:0] o_cnt,
   output logic         o_err
);

   logic [W-1:0] r_cnt;
   sb_op_e       w_op;

   assign w_op  = sb_op(i_inc, i_dec);
   assign o_cnt = r_cnt;
   assign o_err = ((w_op == SB_INC) && (r_cnt == '1)) ||
                  ((w_op == SB_DEC) && (r_cnt == '0));

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_cnt <= '0;
      end else begin
         case (w_op)
            SB_INC:  if (r_cnt != '1) r_cnt <= r_cnt + W'(1);
            SB_DEC:  if (r_cnt != '0) r_cnt <= r_cnt - W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/pipe_wb_regfile.sv
// 32x32 register file with r0 tied to zero, two async read ports and a per-register
// pending-write scoreboard. Define REGFILE_BYPASS_EN for same-cycle WB write-through.
module pipe_wb_regfile
   import pipe_pkg::*;
(
   input  logic          clock,
   input  logic          resetn,
   input  logic [AW-1:0] rna,
   input  logic [AW-1:0] rnb,
   output logic [DW-1:0] qa,
   output logic [DW-1:0] qb,
   output logic          busya,
   output logic          busyb,
   input  logic          iss,
   input  logic [AW-1:0] issrn,
   input  logic          wwreg,
   input  logic [AW-1:0] wrn,
   input  logic [DW-1:0] wdi,
   output logic          sb_err
);

   logic [DW-1:0] r_regs [NREG];
   logic          r_sb_err;

   logic [CW-1:0] w_cnt [NREG];
   logic [NREG-1:0] w_err;
   logic          w_wr;

   assign w_wr = wwreg && (wrn != REG_ZERO);

   // r0 never has a counter: index 0 can never be busy or raise an error.
   assign w_cnt[0] = '0;
   assign w_err[0] = 1'b0;

   for (genvar g = 1; g < NREG; g++) begin : g_sb
      pipe_sb_cnt #(.W(CW)) u_cnt (
         .clock  (clock),
         .resetn (resetn),
         .i_inc  (iss   && (issrn == AW'(g))),
         .i_dec  (wwreg && (wrn   == AW'(g))),
         .o_cnt  (w_cnt[g]),
         .o_err  (w_err[g])
      );
   end

   // NOTE: the storage array is reset because the architectural state must read zero after reset.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
         r_sb_err <= 1'b0;
      end else begin
         if (w_wr) r_regs[wrn] <= wdi;
         r_sb_err <= r_sb_err | (|w_err);
      end
   end

   assign sb_err = r_sb_err;

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      qa    = (rna == REG_ZERO) ? '0 : r_regs[rna];
      qb    = (rnb == REG_ZERO) ? '0 : r_regs[rnb];
      busya = (w_cnt[rna] != '0);
      busyb = (w_cnt[rnb] != '0);
`ifdef REGFILE_BYPASS_EN
      if (w_wr && (wrn == rna)) begin
         qa = wdi;
         if ((w_cnt[rna] == CW'(1)) && !(iss && (issrn == rna))) busya = 1'b0;
      end
      if (w_wr && (wrn == rnb)) begin
         qb = wdi;
         if ((w_cnt[rnb] == CW'(1)) && !(iss && (issrn == rnb))) busyb = 1'b0;
      end
`endif
   end

endmodule
